// File: rtl/conv_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : conv_accumulator (with internal ADDER)
//  Description : Sums KERNEL_SIZE IEEE-754 single-precision products into one
//                output-pixel value. ADDER is the combinational fp32
//                add/subtract unit that the accumulator feeds back through.
//  Revision    : 1.0 - initial release
// ============================================================================

module ADDER (
  input  logic [31:0] OP_A,
  input  logic [31:0] OP_B,
  input  logic        OP,
  output logic [31:0] IEEE_FORMAT
);

  logic        w_sa, w_sb, w_swap, w_sub;
  logic        w_sign_big, w_sign_small;
  logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf;
  logic [7:0]  w_ea, w_eb, w_e_big, w_e_small, w_diff, w_sh;
  logic [23:0] w_ma, w_mb, w_m_big, w_m_small;
  logic [5:0]  w_shamt;
  logic [55:0] w_shifted;
  logic [26:0] w_big_ext, w_small_ext, w_norm;
  logic [27:0] w_sum;
  logic [4:0]  w_lz;
  logic [9:0]  w_exp_n, w_exp_f;
  logic [24:0] w_rnd;
  logic        w_round_up, w_hidden;
  logic [22:0] w_frac;

  // Align, add/subtract, normalise and round to nearest-even in one pass
  always_comb begin
    w_sa    = OP_A[31];
    w_sb    = OP_B[31] ^ OP;
    w_a_nan = (OP_A[30:23] == 8'hFF) && (OP_A[22:0] != 23'd0);
    w_b_nan = (OP_B[30:23] == 8'hFF) && (OP_B[22:0] != 23'd0);
    w_a_inf = (OP_A[30:23] == 8'hFF) && (OP_A[22:0] == 23'd0);
    w_b_inf = (OP_B[30:23] == 8'hFF) && (OP_B[22:0] == 23'd0);

    // Subnormals use an effective exponent of 1 and no hidden bit
    w_ea = (OP_A[30:23] == 8'd0) ? 8'd1 : OP_A[30:23];
    w_eb = (OP_B[30:23] == 8'd0) ? 8'd1 : OP_B[30:23];
    w_ma = {(OP_A[30:23] != 8'd0), OP_A[22:0]};
    w_mb = {(OP_B[30:23] != 8'd0), OP_B[22:0]};

    // Raw-bit compare orders magnitudes correctly for IEEE encodings
    w_swap       = OP_B[30:0] > OP_A[30:0];
    w_e_big      = w_swap ? w_eb : w_ea;
    w_e_small    = w_swap ? w_ea : w_eb;
    w_m_big      = w_swap ? w_mb : w_ma;
    w_m_small    = w_swap ? w_ma : w_mb;
    w_sign_big   = w_swap ? w_sb : w_sa;
    w_sign_small = w_swap ? w_sa : w_sb;
    w_sub        = w_sign_big ^ w_sign_small;

    // Shifts beyond 32 push every small-operand bit into the sticky field
    w_diff      = w_e_big - w_e_small;
    w_shamt     = (w_diff > 8'd32) ? 6'd32 : w_diff[5:0];
    w_shifted   = {w_m_small, 32'd0} >> w_shamt;
    w_small_ext = {w_shifted[55:30], |w_shifted[29:0]};
    w_big_ext   = {w_m_big, 3'b000};

    w_sum = w_sub ? ({1'b0, w_big_ext} - {1'b0, w_small_ext})
                  : ({1'b0, w_big_ext} + {1'b0, w_small_ext});

    w_lz = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (w_sum[i]) w_lz = 5'(26 - i);
    end

    // Left shift is limited so the exponent never drops below 1 (subnormal)
    w_sh    = 8'd0;
    w_norm  = w_sum[26:0];
    w_exp_n = {2'b00, w_e_big};
    if (w_sum[27]) begin
      w_norm  = {w_sum[27:2], w_sum[1] | w_sum[0]};
      w_exp_n = {2'b00, w_e_big} + 10'd1;
    end else begin
      w_sh    = ({3'b000, w_lz} < w_e_big) ? {3'b000, w_lz} : (w_e_big - 8'd1);
      w_norm  = w_sum[26:0] << w_sh;
      w_exp_n = {2'b00, w_e_big} - {2'b00, w_sh};
    end

    w_round_up = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
    w_rnd      = {1'b0, w_norm[26:3]} + {24'd0, w_round_up};
    w_exp_f    = w_exp_n + {9'd0, w_rnd[24]};
    w_hidden   = w_rnd[24] | w_rnd[23];
    w_frac     = w_rnd[24] ? w_rnd[23:1] : w_rnd[22:0];

    if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (w_sa != w_sb)))
      IEEE_FORMAT = 32'h7FC0_0000;
    else if (w_a_inf)
      IEEE_FORMAT = {w_sa, 8'hFF, 23'd0};
    else if (w_b_inf)
      IEEE_FORMAT = {w_sb, 8'hFF, 23'd0};
    else if (w_sum == 28'd0)
      IEEE_FORMAT = {(~w_sub) & w_sign_big, 31'd0};
    else if (w_exp_f >= 10'd255)
      IEEE_FORMAT = {w_sign_big, 8'hFF, 23'd0};
    else
      IEEE_FORMAT = {w_sign_big, (w_hidden ? w_exp_f[7:0] : 8'h00), w_frac};
  end

endmodule

module conv_accumulator #(
  parameter int KERNEL_SIZE = 9,
  parameter int CNT_W       = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CLEAR,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [31:0] IN_DATA,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [31:0] OUT_DATA,
  output logic        BUSY
);

  localparam logic [1:0]       c_st_idle  = 2'd0;
  localparam logic [1:0]       c_st_accum = 2'd1;
  localparam logic [1:0]       c_st_done  = 2'd2;
  localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(KERNEL_SIZE - 1);

  logic [1:0]       r_state, w_next_state;
  logic [31:0]      r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      w_sum;
  logic             w_accept;

  ADDER u_adder (
    .OP_A        (r_acc),
    .OP_B        (IN_DATA),
    .OP          (1'b0),
    .IEEE_FORMAT (w_sum)
  );

  assign w_accept = IN_VALID && IN_READY;

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= c_st_idle;
    else      r_state <= w_next_state;
  end

  // Next-state decode; CLEAR overrides every transition
  always_comb begin
    w_next_state = r_state;
    if (CLEAR) begin
      w_next_state = c_st_idle;
    end else begin
      case (r_state)
        c_st_idle:
          if (w_accept) w_next_state = (KERNEL_SIZE == 1) ? c_st_done : c_st_accum;
        c_st_accum:
          if (w_accept && (r_cnt == c_last_cnt)) w_next_state = c_st_done;
        c_st_done:
          if (OUT_READY) w_next_state = c_st_idle;
        default:
          w_next_state = c_st_idle;
      endcase
    end
  end

  // Handshake and status outputs decoded from state; CLEAR masks both strobes
  always_comb begin
    IN_READY  = (r_state != c_st_done) && !CLEAR;
    OUT_VALID = (r_state == c_st_done) && !CLEAR;
    BUSY      = (r_state != c_st_idle);
    OUT_DATA  = r_acc;
  end

  // Accumulator and sample counter: first sample loads, the rest add
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_acc <= 32'd0;
      r_cnt <= '0;
    end else if (CLEAR) begin
      r_acc <= 32'd0;
      r_cnt <= '0;
    end else begin
      case (r_state)
        c_st_idle:
          if (w_accept) begin
            r_acc <= IN_DATA;
            r_cnt <= CNT_W'(1);
          end
        c_st_accum:
          if (w_accept) begin
            r_acc <= w_sum;
            r_cnt <= r_cnt + CNT_W'(1);
          end
        c_st_done:
          if (OUT_READY) r_cnt <= '0;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv_accumulator
//  Description : Directed self-checking bench for conv_accumulator, with one
//                KERNEL_SIZE=3 instance and one KERNEL_SIZE=2 instance.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps

module tb_conv_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        clear3 = 1'b0, iv3 = 1'b0, ordy3 = 1'b0;
  logic [31:0] id3 = 32'd0;
  logic        ir3, ov3, busy3;
  logic [31:0] od3;

  logic        clear2 = 1'b0, iv2 = 1'b0, ordy2 = 1'b0;
  logic [31:0] id2 = 32'd0;
  logic        ir2, ov2, busy2;
  logic [31:0] od2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  conv_accumulator #(.KERNEL_SIZE(3), .CNT_W(4)) dut3 (
    .CLK(clk), .RST(rst_n), .CLEAR(clear3), .IN_VALID(iv3), .IN_READY(ir3),
    .IN_DATA(id3), .OUT_VALID(ov3), .OUT_READY(ordy3), .OUT_DATA(od3), .BUSY(busy3)
  );

  conv_accumulator #(.KERNEL_SIZE(2), .CNT_W(4)) dut2 (
    .CLK(clk), .RST(rst_n), .CLEAR(clear2), .IN_VALID(iv2), .IN_READY(ir2),
    .IN_DATA(id2), .OUT_VALID(ov2), .OUT_READY(ordy2), .OUT_DATA(od2), .BUSY(busy2)
  );

  // Drive one cycle of stimulus on the falling edge, settle, then return
  task automatic drive3(input logic c, input logic v, input logic [31:0] d, input logic r);
    @(negedge clk);
    clear3 = c; iv3 = v; id3 = d; ordy3 = r;
    #1;
  endtask

  task automatic drive2(input logic v, input logic [31:0] d, input logic r);
    @(negedge clk);
    clear2 = 1'b0; iv2 = v; id2 = d; ordy2 = r;
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      iv3 = 1'($urandom); id3 = $urandom; ordy3 = 1'($urandom);
      #1;
      n_checks++; if (ov3 !== 1'b0) begin n_fail++; $display("FAIL reset_ov: got %b want 0", ov3); end
      n_checks++; if (od3 !== 32'h0) begin n_fail++; $display("FAIL reset_od: got %h want 00000000", od3); end
      n_checks++; if (busy3 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy3); end
      n_checks++; if (ir3 !== 1'b1) begin n_fail++; $display("FAIL reset_ir: got %b want 1", ir3); end
    end
    @(negedge clk);
    rst_n = 1'b1; iv3 = 1'b0; id3 = 32'd0; ordy3 = 1'b1;
    #1;
  endtask

  task automatic test_back_to_back;
    drive3(1'b0, 1'b1, 32'h3F000000, 1'b1);
    n_checks++; if (ir3 !== 1'b1) begin n_fail++; $display("FAIL b2b_ir0: got %b want 1", ir3); end
    drive3(1'b0, 1'b1, 32'h3EE00000, 1'b1);
    n_checks++; if (ir3 !== 1'b1) begin n_fail++; $display("FAIL b2b_ir1: got %b want 1", ir3); end
    drive3(1'b0, 1'b1, 32'hBEE00000, 1'b1);
    n_checks++; if (ov3 !== 1'b0) begin n_fail++; $display("FAIL b2b_ov_early: got %b want 0", ov3); end
    drive3(1'b0, 1'b0, 32'h0, 1'b1);
    n_checks++; if (ov3 !== 1'b1) begin n_fail++; $display("FAIL b2b_ov: got %b want 1", ov3); end
    n_checks++; if (od3 !== 32'h3F000000) begin n_fail++; $display("FAIL b2b_od: got %h want 3f000000", od3); end
    n_checks++; if (ir3 !== 1'b0) begin n_fail++; $display("FAIL b2b_ir_done: got %b want 0", ir3); end
    drive3(1'b0, 1'b0, 32'h0, 1'b1);
    n_checks++; if (ov3 !== 1'b0) begin n_fail++; $display("FAIL b2b_ov_after: got %b want 0", ov3); end
    n_checks++; if (busy3 !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got %b want 0", busy3); end
  endtask

  task automatic test_kernel2;
    drive2(1'b1, 32'h3EE00000, 1'b1);
    drive2(1'b1, 32'hBEE00000, 1'b1);
    drive2(1'b0, 32'h0, 1'b1);
    n_checks++; if (ov2 !== 1'b1) begin n_fail++; $display("FAIL k2_cancel_ov: got %b want 1", ov2); end
    n_checks++; if (od2 !== 32'h00000000) begin n_fail++; $display("FAIL k2_cancel_od: got %h want 00000000", od2); end
    drive2(1'b1, 32'h3EE00000, 1'b1);
    n_checks++; if (ov2 !== 1'b0) begin n_fail++; $display("FAIL k2_idle_ov: got %b want 0", ov2); end
    drive2(1'b1, 32'h3EE00000, 1'b1);
    drive2(1'b0, 32'h0, 1'b1);
    n_checks++; if (ov2 !== 1'b1) begin n_fail++; $display("FAIL k2_sum_ov: got %b want 1", ov2); end
    n_checks++; if (od2 !== 32'h3F600000) begin n_fail++; $display("FAIL k2_sum_od: got %h want 3f600000", od2); end
    drive2(1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_backpressure;
    drive3(1'b0, 1'b1, 32'h3F000000, 1'b0);
    drive3(1'b0, 1'b1, 32'h3EE00000, 1'b0);
    drive3(1'b0, 1'b1, 32'hBEE00000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive3(1'b0, (i % 2 == 0), 32'h40000000, 1'b0);
      n_checks++; if (ov3 !== 1'b1) begin n_fail++; $display("FAIL bp_ov[%0d]: got %b want 1", i, ov3); end
      n_checks++; if (od3 !== 32'h3F000000) begin n_fail++; $display("FAIL bp_od[%0d]: got %h want 3f000000", i, od3); end
      n_checks++; if (ir3 !== 1'b0) begin n_fail++; $display("FAIL bp_ir[%0d]: got %b want 0", i, ir3); end
      n_checks++; if (dut3.r_cnt !== 4'd3) begin n_fail++; $display("FAIL bp_cnt[%0d]: got %0d want 3", i, dut3.r_cnt); end
    end
    // Handshake cycle: the sample presented here must be ignored
    drive3(1'b0, 1'b1, 32'h40000000, 1'b1);
    drive3(1'b0, 1'b1, 32'h3EE00000, 1'b1);
    n_checks++; if (dut3.r_cnt !== 4'd0) begin n_fail++; $display("FAIL bp_cnt_reset: got %0d want 0", dut3.r_cnt); end
    drive3(1'b0, 1'b1, 32'h3EE00000, 1'b1);
    drive3(1'b0, 1'b1, 32'hBEE00000, 1'b1);
    drive3(1'b0, 1'b0, 32'h0, 1'b1);
    n_checks++; if (ov3 !== 1'b1) begin n_fail++; $display("FAIL bp_next_ov: got %b want 1", ov3); end
    n_checks++; if (od3 !== 32'h3EE00000) begin n_fail++; $display("FAIL bp_next_od: got %h want 3ee00000", od3); end
    drive3(1'b0, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_gapped;
    drive3(1'b0, 1'b1, 32'h3F000000, 1'b1);
    n_checks++; if (dut3.r_cnt !== 4'd0) begin n_fail++; $display("FAIL gap_cnt0: got %0d want 0", dut3.r_cnt); end
    drive3(1'b0, 1'b0, 32'hDEADBEEF, 1'b1);
    n_checks++; if (dut3.r_cnt !== 4'd1) begin n_fail++; $display("FAIL gap_cnt1: got %0d want 1", dut3.r_cnt); end
    drive3(1'b0, 1'b1, 32'h3EE00000, 1'b1);
    n_checks++; if (dut3.r_cnt !== 4'd1) begin n_fail++; $display("FAIL gap_cnt1b: got %0d want 1", dut3.r_cnt); end
    drive3(1'b0, 1'b0, 32'hDEADBEEF, 1'b1);
    n_checks++; if (dut3.r_cnt !== 4'd2) begin n_fail++; $display("FAIL gap_cnt2: got %0d want 2", dut3.r_cnt); end
    n_checks++; if (ov3 !== 1'b0) begin n_fail++; $display("FAIL gap_ov_early: got %b want 0", ov3); end
    drive3(1'b0, 1'b1, 32'hBEE00000, 1'b1);
    drive3(1'b0, 1'b0, 32'h0, 1'b1);
    n_checks++; if (ov3 !== 1'b1) begin n_fail++; $display("FAIL gap_ov: got %b want 1", ov3); end
    n_checks++; if (od3 !== 32'h3F000000) begin n_fail++; $display("FAIL gap_od: got %h want 3f000000", od3); end
    drive3(1'b0, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_clear;
    drive3(1'b0, 1'b1, 32'h3F000000, 1'b1);
    drive3(1'b0, 1'b1, 32'h3F000000, 1'b1);
    drive3(1'b1, 1'b1, 32'h40000000, 1'b1);
    n_checks++; if (ir3 !== 1'b0) begin n_fail++; $display("FAIL clr_ir: got %b want 0", ir3); end
    n_checks++; if (ov3 !== 1'b0) begin n_fail++; $display("FAIL clr_ov: got %b want 0", ov3); end
    drive3(1'b0, 1'b1, 32'h3EE00000, 1'b1);
    n_checks++; if (busy3 !== 1'b0) begin n_fail++; $display("FAIL clr_busy: got %b want 0", busy3); end
    n_checks++; if (od3 !== 32'h0) begin n_fail++; $display("FAIL clr_acc: got %h want 00000000", od3); end
    n_checks++; if (dut3.r_cnt !== 4'd0) begin n_fail++; $display("FAIL clr_cnt: got %0d want 0", dut3.r_cnt); end
    drive3(1'b0, 1'b1, 32'h3EE00000, 1'b1);
    drive3(1'b0, 1'b1, 32'hBEE00000, 1'b1);
    drive3(1'b0, 1'b0, 32'h0, 1'b0);
    n_checks++; if (od3 !== 32'h3EE00000) begin n_fail++; $display("FAIL clr_od: got %h want 3ee00000", od3); end
    n_checks++; if (ov3 !== 1'b1) begin n_fail++; $display("FAIL clr_ov_done: got %b want 1", ov3); end
    // CLEAR together with OUT_READY in DONE: no result is delivered
    drive3(1'b1, 1'b0, 32'h0, 1'b1);
    n_checks++; if (ov3 !== 1'b0) begin n_fail++; $display("FAIL clr_done_ov: got %b want 0", ov3); end
    drive3(1'b0, 1'b0, 32'h0, 1'b1);
    n_checks++; if (busy3 !== 1'b0) begin n_fail++; $display("FAIL clr_done_busy: got %b want 0", busy3); end
    n_checks++; if (od3 !== 32'h0) begin n_fail++; $display("FAIL clr_done_acc: got %h want 00000000", od3); end
  endtask

  task automatic test_reset_mid;
    drive3(1'b0, 1'b1, 32'h3F000000, 1'b1);
    drive3(1'b0, 1'b1, 32'h3F000000, 1'b1);
    drive3(1'b0, 1'b0, 32'h0, 1'b1);
    rst_n = 1'b0;
    #1;
    n_checks++; if (busy3 !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b want 0", busy3); end
    n_checks++; if (od3 !== 32'h0) begin n_fail++; $display("FAIL rst_mid_acc: got %h want 00000000", od3); end
    drive3(1'b0, 1'b0, 32'h0, 1'b1);
    rst_n = 1'b1;
    drive3(1'b0, 1'b1, 32'h3EE00000, 1'b1);
    drive3(1'b0, 1'b1, 32'h3EE00000, 1'b1);
    drive3(1'b0, 1'b1, 32'hBEE00000, 1'b1);
    drive3(1'b0, 1'b0, 32'h0, 1'b1);
    n_checks++; if (ov3 !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ov: got %b want 1", ov3); end
    n_checks++; if (od3 !== 32'h3EE00000) begin n_fail++; $display("FAIL rst_mid_od: got %h want 3ee00000", od3); end
    drive3(1'b0, 1'b0, 32'h0, 1'b1);
  endtask

  initial begin
    test_reset;
    test_back_to_back;
    test_kernel2;
    test_backpressure;
    test_gapped;
    test_clear;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/conv_accumulator.md
# conv_accumulator

Sequential floating-point accumulator sitting directly downstream of the combinational IEEE-754 single-precision `ADDER`. It consumes one 32-bit product per accepted handshake and sums `KERNEL_SIZE` products into one output-pixel value. It feeds the summed value into the convolution accelerator's output path. The block instantiates `ADDER` internally with `OP_A` = accumulator register, `OP_B` = incoming product and `OP` = 0 (add).

## Interface
- `KERNEL_SIZE`, default 9: products summed per output value; legal range ≥1.
- `CNT_W`, default 4: sample-counter width; must satisfy 2^CNT_W ≥ `KERNEL_SIZE`.

- `CLK`  in  1  single clock; all state updates on the rising edge.
- `RST`  in  1  asynchronous, active-low reset.
- `CLEAR`  in  1  synchronous abort of the current window; highest priority after `RST`.
- `IN_VALID`  in  1  `IN_DATA` holds a valid product.
- `IN_READY`  out  1  block can accept a product this cycle.
- `IN_DATA`  in  32  IEEE-754 single-precision product.
- `OUT_VALID`  out  1  `OUT_DATA` holds a completed sum.
- `OUT_READY`  in  1  downstream accepts `OUT_DATA`.
- `OUT_DATA`  out  32  IEEE-754 sum; driven directly from the accumulator register.
- `BUSY`  out  1  high in ACCUM or DONE, i.e. a window is in progress or a result is waiting.

## Operation
- Registers:
  - `ACC` (32 bits).
  - `CNT` (`CNT_W` bits).
  - State: IDLE, ACCUM or DONE.
- A product is accepted when `IN_VALID` && `IN_READY`.
- `IN_READY` = (state ≠ DONE) && !`CLEAR`, decoded combinationally from the state.
- IDLE:
  - On accept, `ACC` ← `IN_DATA` (direct load, no add with zero) and `CNT` ← 1.
  - Next state is ACCUM, or DONE if `KERNEL_SIZE` = 1.
- ACCUM:
  - On accept, `ACC` ← `ADDER`.`IEEE_FORMAT` (`ACC` + `IN_DATA`) and `CNT` ← `CNT`+1.
  - If `CNT` = `KERNEL_SIZE`−1 at the time of the accept, next state is DONE.
  - Cycles without an accept leave `ACC`, `CNT` and state unchanged.
- DONE:
  - `OUT_VALID` = 1 and `IN_READY` = 0.
  - `IN_VALID` is ignored.
  - On `OUT_READY` = 1: next state is IDLE and `CNT` ← 0. `ACC` keeps its value until the next load.
- `OUT_VALID` = (state == DONE) && !`CLEAR`.
- `CLEAR` = 1, in any state:
  - Next state is IDLE, `ACC` ← 0, `CNT` ← 0.
  - `IN_READY` and `OUT_VALID` are forced to 0 in that cycle, so no sample is lost and no result is delivered.
- Arithmetic is delegated entirely to `ADDER`. The block does no rounding, normalisation or special-value handling of its own; exact cancellation yields +0 (0x00000000), as `ADDER` produces.

## Timing
- Reset values (`RST` low, asynchronous):
  - State IDLE; `ACC` = 0, `CNT` = 0.
  - `OUT_VALID` = 0, `OUT_DATA` = 0x00000000, `BUSY` = 0, `IN_READY` = 1.
- Release of `RST` takes effect at the next rising edge.
- Throughput is one product per cycle while in IDLE or ACCUM.
- Latency: `OUT_VALID` rises in the cycle after the `KERNEL_SIZE`-th accept.
- Minimum window period is `KERNEL_SIZE`+1 cycles: at least one DONE cycle, with `IN_READY` low, separates windows.
- Back-pressure: while `OUT_READY` = 0 in DONE, `OUT_VALID` stays 1 and `OUT_DATA` stays stable.
- The `ADDER` path from `ACC`/`IN_DATA` to `ACC` D-input is one combinational cycle; no multicycle paths.
- `RST` asserted mid-window clears immediately; the partial sum is discarded.
- `CLEAR` and `OUT_READY` both high in DONE: `CLEAR` wins and no handshake completes.

## Test plan
- Reset: hold `RST` = 0 for 3 cycles with random inputs -> `OUT_VALID` = 0, `OUT_DATA` = 0, `BUSY` = 0, `IN_READY` = 1 throughout.
- `KERNEL_SIZE` = 3, back-to-back 0x3F000000, 0x3EE00000, 0xBEE00000 with `OUT_READY` = 1 -> `OUT_VALID` is high exactly one cycle after the third accept with `OUT_DATA` = 0x3F000000, then IDLE.
- `KERNEL_SIZE` = 2, inputs 0x3EE00000, 0xBEE00000 -> `OUT_DATA` = 0x00000000. Inputs 0x3EE00000, 0x3EE00000 -> `OUT_DATA` = 0x3F600000.
- Back-pressure: after a completed window hold `OUT_READY` = 0 for 5 cycles while pulsing `IN_VALID` -> `OUT_VALID` and `OUT_DATA` are stable, `IN_READY` = 0, no sample is counted. The next window sums only post-handshake inputs.
- Gapped input with `KERNEL_SIZE` = 3: `IN_VALID` high on alternate cycles, inputs 0x3F000000, 0x3EE00000, 0xBEE00000 -> the result is identical to the back-to-back case, and `CNT` advances only on accepts.
- Abort: `CLEAR` after 2 accepts (0x3F000000, 0x3F000000), then 0x3EE00000 ×2 and 0xBEE00000 -> `OUT_DATA` = 0x3EE00000, unaffected by the pre-clear data. Repeat with `RST` pulsed low mid-window -> same result.
